mcb_burst_writer: RTL and testbench

- User-port initiator for one MCB write port of the DDR2 video memory wrapper.
- Accepts a valid/ready stream of 32-bit pixel words and loads them into the port write FIFO.
- After each BURST_LEN words, issues one write command with the current byte address, then advances the address linearly through a frame buffer and wraps at the frame end.
- Sits between the pixel producer (Mandelbrot engine) and the wrapper's p0/p1 cmd/wr signals, all in the clk0 domain.

---
 rtl/mcb_burst_writer_if.sv | 27 ++
 rtl/mcb_burst_writer.sv | 129 ++++++++++++
 tb/tb_mcb_burst_writer.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcb_burst_writer_if.sv
// Stream-in and MCB cmd/wr port bundle for the burst writer.
// The master modport is the writer; the slave modport is the producer plus the MCB side.
interface mcb_burst_writer_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_full;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_full;
  logic        wr_underrun;

  modport master (
    input  s_data, s_valid, cmd_full, wr_full, wr_underrun,
    output s_ready, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_data, wr_mask
  );

  modport slave (
    output s_data, s_valid, cmd_full, wr_full, wr_underrun,
    input  s_ready, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_data, wr_mask
  );
endinterface

// File: rtl/mcb_burst_writer.sv
// MCB write-port initiator: packs a pixel stream into BURST_LEN-word bursts and
// issues one write command per burst, walking linearly through a frame buffer.
module mcb_burst_writer #(
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter logic [29:0] BASE_ADDR   = 30'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 calib_done,
  input  logic                 frame_start,
  mcb_burst_writer_if.master   bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 error
);

  localparam int unsigned BW        = 7;
  localparam int unsigned WW        = $clog2(FRAME_WORDS + 1);
  localparam int unsigned ADDR_STEP = BURST_LEN * 4;

  typedef enum logic [1:0] {IDLE, FILL, CMD} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [WW-1:0]   word_q, word_d;
  logic [29:0]     addr_q, addr_d;
  logic            pend_q, pend_d;
  logic            error_q, error_d;

  logic            s_ready_c;
  logic            accept_c;
  logic            cmd_en_c;
  logic            frame_done_c;
  logic            restart_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      word_q  <= '0;
      addr_q  <= BASE_ADDR;
      pend_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    word_d       = word_q;
    addr_d       = addr_q;
    pend_d       = pend_q;
    error_d      = error_q | bus.wr_underrun;
    s_ready_c    = 1'b0;
    accept_c     = 1'b0;
    cmd_en_c     = 1'b0;
    frame_done_c = 1'b0;

    // A restart between bursts takes effect at once; mid-burst it is deferred.
    restart_c = frame_start && ((state_q == IDLE) || ((state_q == FILL) && (beat_q == '0)));
    if (restart_c) begin
      addr_d = BASE_ADDR;
      word_d = '0;
      pend_d = 1'b0;
    end else if (frame_start) begin
      pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (calib_done) state_d = FILL;
      end
      FILL: begin
        s_ready_c = !bus.wr_full;
        accept_c  = s_ready_c && bus.s_valid;
        if (accept_c) begin
          if (beat_q == BW'(BURST_LEN - 1)) begin
            beat_d  = '0;
            state_d = CMD;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      CMD: begin
        if (!bus.cmd_full) begin
          cmd_en_c = 1'b1;
          state_d  = FILL;
          // Deferred restart replaces the normal advance and suppresses frame_done.
          if (pend_q || frame_start) begin
            addr_d = BASE_ADDR;
            word_d = '0;
            pend_d = 1'b0;
          end else if (word_q + WW'(BURST_LEN) == WW'(FRAME_WORDS)) begin
            addr_d       = BASE_ADDR;
            word_d       = '0;
            frame_done_c = 1'b1;
          end else begin
            addr_d = addr_q + 30'(ADDR_STEP);
            word_d = word_q + WW'(BURST_LEN);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_ready       = s_ready_c;
  assign bus.wr_en         = accept_c;
  assign bus.wr_data       = bus.s_data;
  assign bus.wr_mask       = 4'b0000;
  assign bus.cmd_en        = cmd_en_c;
  assign bus.cmd_instr     = 3'b000;
  assign bus.cmd_bl        = 6'(BURST_LEN - 1);
  assign bus.cmd_byte_addr = addr_q;

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_c;
  assign error      = error_q;

endmodule

// File: tb/tb_mcb_burst_writer.sv
// Scoreboard bench for mcb_burst_writer with a 64-word frame of two 32-word bursts.
module tb_mcb_burst_writer;

  localparam int unsigned BL = 32;
  localparam int unsigned FW = 64;

  typedef struct packed {
    logic [29:0] addr;
    logic        fd;
    logic [5:0]  bl;
    logic [2:0]  instr;
    logic [3:0]  mask;
  } cmd_t;

  logic clk = 1'b0;
  logic reset;
  logic calib_done;
  logic frame_start;
  logic busy, frame_done, error;

  mcb_burst_writer_if bus();

  mcb_burst_writer #(.BURST_LEN(BL), .FRAME_WORDS(FW), .BASE_ADDR(30'd0)) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done), .frame_start(frame_start),
    .bus(bus), .busy(busy), .frame_done(frame_done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_data[$];
  logic [31:0] obs_data[$];
  cmd_t        exp_cmd[$];
  cmd_t        obs_cmd[$];
  cmd_t        mon_c;

  // Capture DUT output events mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.wr_en) obs_data.push_back(bus.wr_data);
      if (bus.cmd_en) begin
        mon_c.addr  = bus.cmd_byte_addr;
        mon_c.fd    = frame_done;
        mon_c.bl    = bus.cmd_bl;
        mon_c.instr = bus.cmd_instr;
        mon_c.mask  = bus.wr_mask;
        obs_cmd.push_back(mon_c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cmd_t mk_cmd(input logic [29:0] a, input logic fd);
    cmd_t c;
    c.addr = a; c.fd = fd; c.bl = 6'(BL - 1); c.instr = 3'b000; c.mask = 4'b0000;
    return c;
  endfunction

  // Drive n consecutive words, pushing expectations; reports cycles used and timeouts.
  task automatic stream(input logic [31:0] base, input int n, input bit fs_first,
                        output int cycles, output int timeouts);
    bit acc;
    cycles = 0;
    timeouts = 0;
    for (int i = 0; i < n; i++) begin
      bus.s_data  = base + 32'(i);
      bus.s_valid = 1'b1;
      exp_data.push_back(base + 32'(i));
      if (i == 0 && fs_first) frame_start = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge clk);
        acc = bus.s_ready;
        tick();
        frame_start = 1'b0;
        cycles++;
      end
      if (!acc) timeouts++;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_cmds(input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (obs_cmd.size() >= n) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; calib_done = 1'b0; frame_start = 1'b0;
    bus.s_data = '0; bus.s_valid = 1'b1; bus.cmd_full = 1'b0;
    bus.wr_full = 1'b0; bus.wr_underrun = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if ({bus.s_ready, bus.cmd_en, bus.wr_en, busy, frame_done, error} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000000",
               {bus.s_ready, bus.cmd_en, bus.wr_en, busy, frame_done, error});
    end
    n_checks++;
    if (bus.cmd_byte_addr !== 30'd0) begin
      n_fail++; $display("FAIL reset_addr: got %h want 0", bus.cmd_byte_addr);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic test_calib_gate();
    int bad = 0;
    tick();
    reset = 1'b1;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.s_ready !== 1'b0 || bus.wr_en !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL calib_gate: %0d cycles accepted/busy, want 0", bad);
    end
    bus.s_valid = 1'b0;
    calib_done = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.s_ready !== 1'b0) begin
      n_fail++; $display("FAIL calib_early: s_ready=%b want 0", bus.s_ready);
    end
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if (bus.s_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL calib_ready: s_ready=%b busy=%b want 1 1", bus.s_ready, busy);
    end
    n_checks++;
    if (obs_data.size() !== 0) begin
      n_fail++; $display("FAIL calib_no_wr: %0d writes want 0", obs_data.size());
    end
    tick();
  endtask

  task automatic test_single_burst();
    int cyc, to;
    bit ok;
    logic [31:0] e, o;
    cmd_t ec, oc;
    exp_cmd.push_back(mk_cmd(30'h0, 1'b0));
    stream(32'h0, 32, 1'b0, cyc, to);
    n_checks++;
    if (to != 0 || cyc != 32) begin
      n_fail++; $display("FAIL burst_throughput: cycles=%0d timeouts=%0d want 32 0", cyc, to);
    end
    wait_cmds(1, ok);
    n_checks++;
    if (!ok || obs_data.size() != 32) begin
      n_fail++; $display("FAIL burst_counts: cmds=%0d words=%0d want 1 32", obs_cmd.size(), obs_data.size());
    end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      e = exp_data.pop_front(); o = obs_data.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL burst_data: got %h want %h", o, e); end
    end
    while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
      ec = exp_cmd.pop_front(); oc = obs_cmd.pop_front();
      n_checks++;
      if (oc !== ec) begin n_fail++; $display("FAIL burst_cmd: got %h want %h", oc, ec); end
    end
    exp_data.delete(); obs_data.delete();
  endtask

  task automatic test_cmd_backpressure();
    int cyc, to, bad;
    bit ok;
    logic [31:0] e, o;
    cmd_t ec, oc;
    bad = 0;
    bus.cmd_full = 1'b1;
    exp_cmd.push_back(mk_cmd(30'h80, 1'b1));
    stream(32'h100, 32, 1'b0, cyc, to);
    n_checks++;
    if (to != 0) begin n_fail++; $display("FAIL bp_stream: timeouts=%0d want 0", to); end
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cmd_en !== 1'b0 || bus.s_ready !== 1'b0 || bus.wr_en !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL bp_hold: %0d active cycles want 0", bad); end
    bus.s_valid = 1'b0;
    bus.cmd_full = 1'b0;
    wait_cmds(1, ok);
    repeat (4) tick();
    n_checks++;
    if (obs_cmd.size() != 1 || obs_data.size() != 32) begin
      n_fail++; $display("FAIL bp_counts: cmds=%0d words=%0d want 1 32", obs_cmd.size(), obs_data.size());
    end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      e = exp_data.pop_front(); o = obs_data.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL bp_data: got %h want %h", o, e); end
    end
    while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
      ec = exp_cmd.pop_front(); oc = obs_cmd.pop_front();
      n_checks++;
      if (oc !== ec) begin n_fail++; $display("FAIL bp_cmd: got %h want %h", oc, ec); end
    end
    exp_data.delete(); obs_data.delete(); obs_cmd.delete();
  endtask

  task automatic test_wr_full();
    int cyc, to, bad;
    bit ok;
    logic [31:0] e, o;
    cmd_t ec, oc;
    bad = 0;
    exp_cmd.push_back(mk_cmd(30'h0, 1'b0));
    fork
      stream(32'h200, 32, 1'b0, cyc, to);
      begin
        repeat (8) tick();
        bus.wr_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (bus.s_ready !== 1'b0 || bus.wr_en !== 1'b0) bad++;
          tick();
        end
        bus.wr_full = 1'b0;
      end
    join
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL wrfull_stall: %0d active cycles want 0", bad); end
    n_checks++;
    if (to != 0 || cyc != 37) begin
      n_fail++; $display("FAIL wrfull_cycles: cycles=%0d timeouts=%0d want 37 0", cyc, to);
    end
    wait_cmds(1, ok);
    n_checks++;
    if (!ok || obs_data.size() != 32) begin
      n_fail++; $display("FAIL wrfull_counts: cmds=%0d words=%0d want 1 32", obs_cmd.size(), obs_data.size());
    end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      e = exp_data.pop_front(); o = obs_data.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL wrfull_data: got %h want %h", o, e); end
    end
    while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
      ec = exp_cmd.pop_front(); oc = obs_cmd.pop_front();
      n_checks++;
      if (oc !== ec) begin n_fail++; $display("FAIL wrfull_cmd: got %h want %h", oc, ec); end
    end
    exp_data.delete(); obs_data.delete();
  endtask

  // Restart with frame_start on the first word, then 96 words: 0x0, 0x80 (frame_done), 0x0.
  task automatic test_frame_wrap();
    int cyc, to;
    bit ok;
    logic [31:0] e, o;
    cmd_t ec, oc;
    exp_cmd.push_back(mk_cmd(30'h0, 1'b0));
    exp_cmd.push_back(mk_cmd(30'h80, 1'b1));
    exp_cmd.push_back(mk_cmd(30'h0, 1'b0));
    stream(32'h300, 96, 1'b1, cyc, to);
    n_checks++;
    if (to != 0 || cyc != 98) begin
      n_fail++; $display("FAIL wrap_cycles: cycles=%0d timeouts=%0d want 98 0", cyc, to);
    end
    wait_cmds(3, ok);
    n_checks++;
    if (!ok || obs_data.size() != 96) begin
      n_fail++; $display("FAIL wrap_counts: cmds=%0d words=%0d want 3 96", obs_cmd.size(), obs_data.size());
    end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      e = exp_data.pop_front(); o = obs_data.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL wrap_data: got %h want %h", o, e); end
    end
    while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
      ec = exp_cmd.pop_front(); oc = obs_cmd.pop_front();
      n_checks++;
      if (oc !== ec) begin n_fail++; $display("FAIL wrap_cmd: got %h want %h", oc, ec); end
    end
    exp_data.delete(); obs_data.delete();
  endtask

  task automatic test_mid_frame_start();
    int cyc, to;
    bit ok;
    logic [31:0] e, o;
    cmd_t ec, oc;
    exp_cmd.push_back(mk_cmd(30'h80, 1'b0));
    exp_cmd.push_back(mk_cmd(30'h0, 1'b0));
    exp_cmd.push_back(mk_cmd(30'h80, 1'b1));
    stream(32'h400, 10, 1'b0, cyc, to);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    stream(32'h40A, 22, 1'b0, cyc, to);
    stream(32'h500, 64, 1'b0, cyc, to);
    wait_cmds(3, ok);
    n_checks++;
    if (!ok || obs_data.size() != 96) begin
      n_fail++; $display("FAIL midfs_counts: cmds=%0d words=%0d want 3 96", obs_cmd.size(), obs_data.size());
    end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      e = exp_data.pop_front(); o = obs_data.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL midfs_data: got %h want %h", o, e); end
    end
    while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
      ec = exp_cmd.pop_front(); oc = obs_cmd.pop_front();
      n_checks++;
      if (oc !== ec) begin n_fail++; $display("FAIL midfs_cmd: got %h want %h", oc, ec); end
    end
    exp_data.delete(); obs_data.delete();
  endtask

  task automatic test_error_and_reset();
    int bad = 0;
    @(negedge clk);
    n_checks++;
    if (error !== 1'b0) begin n_fail++; $display("FAIL err_initial: got %b want 0", error); end
    tick();
    bus.wr_underrun = 1'b1;
    tick();
    bus.wr_underrun = 1'b0;
    calib_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (error !== 1'b1) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL err_sticky: %0d cycles low want 0", bad); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || bus.s_ready !== 1'b1) begin
      n_fail++; $display("FAIL calib_drop: busy=%b s_ready=%b want 1 1", busy, bus.s_ready);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({error, busy, bus.s_ready, bus.cmd_byte_addr} !== {3'b000, 30'd0}) begin
      n_fail++; $display("FAIL err_reset: error=%b busy=%b s_ready=%b addr=%h want 0 0 0 0",
                         error, busy, bus.s_ready, bus.cmd_byte_addr);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_calib_gate();
    test_single_burst();
    test_cmd_backpressure();
    test_wr_full();
    test_frame_wrap();
    test_mid_frame_start();
    test_error_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
